lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store controller between the RISC-V memory pipeline stage and the byte-addressed data memory (`memory2c`). It accepts one load or store per request handshake and decodes RV32I funct3 into memory length and sign controls. Misaligned halfword and word accesses are either split into sequential byte accesses or rejected as faults, selected at compile time. Each request produces exactly one single-cycle response pulse carrying load data or a fault flag.

## Interface
Parameters:
- ADDR_W, 32, request and memory address width; address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and faults.
- resp_fault  out  1  illegal funct3, or misaligned access when splitting is disabled.
- mem_en, mem_wr  out  1 each  to the memory's enable and wr inputs.
- mem_addr  out  ADDR_W  to the memory's address input.
- mem_length  out  2  to the memory's length input (00 byte, 01 half, 10 word).
- mem_sign  out  1  to the memory's sign input.
- mem_wdata  out  32  to the memory's data_in.
- mem_rdata  in  32  from the memory's data_out; combinational read, same cycle.

## Operation
- FSM states: IDLE, ACCESS, SPLIT, RESP.
- **Accept:** in IDLE, `req_valid` high latches wr, funct3, addr and wdata into request registers.
- **Illegal funct3** (load 011/110/111; store ≥011): go IDLE→RESP with `resp_fault=1`. No memory access.
- **Aligned access** (byte; half with addr[0]=0; word with addr[1:0]=00): IDLE→ACCESS→RESP.
  - ACCESS drives `mem_en=1`, `mem_wr=req_wr`, `mem_length` and `mem_sign` decoded from funct3, `mem_wdata=wdata`.
  - On a load, `mem_rdata` is captured at the end of ACCESS.
- **Misaligned access, MISALIGN_SPLIT_EN defined:** IDLE→SPLIT.
  - A byte counter idx runs 0..N-1, with N=2 (half) or N=4 (word).
  - Each SPLIT cycle drives `mem_length=00`, `mem_sign=0`, `mem_addr=addr+idx` (wraps), `mem_wdata[7:0]=wdata[8*idx+:8]`.
  - Loads capture `mem_rdata[7:0]` into assembly byte idx.
  - After idx=N-1, go to RESP.
  - The assembled value is sign- or zero-extended per funct3 (lh sign-extends from bit 15; lhu zero-extends).
- **RESP:** `resp_valid=1` for one cycle, `resp_rdata` and `resp_fault` valid, then return to IDLE.
- Outside ACCESS/SPLIT, all `mem_*` outputs are 0; `mem_en` is never high in IDLE or RESP.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_fault=0`, all `mem_*` outputs 0, counter 0.
- Latency from the accept edge to `resp_valid`:
  - aligned: 2 cycles;
  - fault: 1 cycle;
  - split half: 3 cycles;
  - split word: 5 cycles.
- Throughput: the next accept is possible in the cycle after RESP.
- `req_valid` while `req_ready=0` is ignored; the requester must hold it until accepted.
- Reset asserted mid-operation: state returns to IDLE and `mem_en` drops immediately.
  - Bytes already written at earlier edges stay written.
  - No response is produced for the aborted request.
- Address wrap: a split word at 0xFFFFFFFF accesses bytes 0xFFFFFFFF, 0x0, 0x1, 0x2.

## Configuration
- MISALIGN_SPLIT_EN defined: the SPLIT state and counter are compiled in; misaligned half/word accesses complete with `resp_fault=0`.
- MISALIGN_SPLIT_EN undefined: no SPLIT logic; misaligned half/word go IDLE→RESP with `resp_fault=1`, `resp_rdata=0`, and no memory access.

## Structure
- Package `lsu_pkg`:
  - state enum;
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - length codes (LEN_BYTE=2'b00, LEN_HALF=2'b01, LEN_WORD=2'b10).
- Sub-module `lsu_load_extend`: combinational sign/zero extension of the assembled bytes per funct3. Shared by the aligned and split paths.

## Test plan
- Aligned lw at 0x100 (memory holds 0xDEADBEEF) → one ACCESS cycle with `mem_length=10`; `resp_valid` 2 cycles after accept; `resp_rdata=0xDEADBEEF`, `resp_fault=0`.
- lb at 0x100 holding byte 0x80 → `resp_rdata=0xFFFFFF80`; the same address with lbu → `resp_rdata=0x00000080`.
- sw 0x11223344 at 0x203 with splitting enabled → 4 SPLIT cycles writing 0x44, 0x33, 0x22, 0x11 to 0x203..0x206; then lw at 0x203 returns 0x11223344. With splitting disabled → `resp_fault=1` and no `mem_en` pulse.
- Load funct3=011 → `resp_valid` 1 cycle after accept with `resp_fault=1`, `resp_rdata=0`, and `mem_en` never high.
- Split lh at 0xFFFFFFFF (bytes 0xFF, 0x00 set to 0x34, 0x92) → `mem_addr` sequence 0xFFFFFFFF then 0x0; `resp_rdata=0xFFFF9234`.
- Assert `rst_n` low during the 2nd SPLIT cycle of a sw → `mem_en` drops at once; only the first byte is modified; no `resp_valid`; after release, `req_ready=1`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
// Optional feature macro: MISALIGN_SPLIT_EN (see lsu_mem_ctrl).
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      SPLIT  = 2'd2,
      RESP   = 2'd3
   } lsu_state_e;

   // RV32I funct3 codes for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Memory length codes; they coincide with funct3[1:0] of every legal access
   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   // True when funct3 names a supported access for the given direction
   function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
      if (wr) begin
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // True when a half/word access is not naturally aligned
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
      case (f3[1:0])
         LEN_HALF: return lsb[0];
         LEN_WORD: return lsb != 2'b00;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of assembled load bytes according to funct3.
// Used for both the aligned and the byte-split load paths.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   // Extend the low byte/half from its top bit for signed loads, zero-fill for unsigned
   always_comb begin
      case (funct3)
         F3_B:    data = {{24{raw[7]}}, raw[7:0]};
         F3_H:    data = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   data = {24'h0, raw[7:0]};
         F3_HU:   data = {16'h0, raw[15:0]};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the memory pipeline stage and memory2c.
// One request per handshake, one single-cycle response pulse per request.
// Define MISALIGN_SPLIT_EN to split misaligned half/word accesses into
// sequential byte accesses; otherwise they are rejected with a fault.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_length,
   output logic              mem_sign,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   lsu_state_e        state_q, state_d;
   logic              wr_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       raw_q;
   logic              fault_q;
   logic [31:0]       ext_data;

   logic accept;
   logic req_illegal;
   logic req_misal;
   logic req_fault;

   assign accept      = (state_q == IDLE) && req_valid;
   assign req_illegal = !f3_legal(req_wr, req_funct3);
   assign req_misal   = is_misaligned(req_funct3, req_addr[1:0]);

`ifdef MISALIGN_SPLIT_EN
   logic [1:0] idx_q;
   logic       split_last;

   assign req_fault  = req_illegal;
   assign split_last = (idx_q == ((f3_q[1:0] == LEN_WORD) ? 2'd3 : 2'd1));
`else
   assign req_fault  = req_illegal || req_misal;
`endif

   // State register; the async reset also drops every mem_* output at once
   // since they are decoded from the state alone
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of process ordering.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Request capture and load-data assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         raw_q   <= 32'h0;
         fault_q <= 1'b0;
      end else if (accept) begin
         wr_q    <= req_wr;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         raw_q   <= 32'h0;
         fault_q <= req_fault;
      end else if (state_q == ACCESS && !wr_q) begin
         raw_q <= mem_rdata;
`ifdef MISALIGN_SPLIT_EN
      end else if (state_q == SPLIT && !wr_q) begin
         raw_q[{idx_q, 3'b000} +: 8] <= mem_rdata[7:0];
`endif
      end
   end

`ifdef MISALIGN_SPLIT_EN
   // Byte index within a split access, restarted on every accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  idx_q <= 2'd0;
      else if (accept)             idx_q <= 2'd0;
      else if (state_q == SPLIT)   idx_q <= idx_q + 2'd1;
   end
`endif

   // Next-state decode
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_fault)      state_d = RESP;
`ifdef MISALIGN_SPLIT_EN
               else if (req_misal) state_d = SPLIT;
`endif
               else                state_d = ACCESS;
            end
         end
         ACCESS: state_d = RESP;
`ifdef MISALIGN_SPLIT_EN
         SPLIT: if (split_last) state_d = RESP;
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   lsu_load_extend u_load_extend (
      .funct3 (f3_q),
      .raw    (raw_q),
      .data   (ext_data)
   );

   // Output decode: memory port only active in ACCESS/SPLIT, response only in RESP
   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == RESP);
      resp_fault = (state_q == RESP) && fault_q;
      resp_rdata = ((state_q == RESP) && !wr_q && !fault_q) ? ext_data : 32'h0;
      mem_en     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_length = LEN_BYTE;
      mem_sign   = 1'b0;
      mem_wdata  = 32'h0;
      case (state_q)
         ACCESS: begin
            mem_en     = 1'b1;
            mem_wr     = wr_q;
            mem_addr   = addr_q;
            mem_length = f3_q[1:0];
            mem_sign   = !wr_q && !f3_q[2];
            mem_wdata  = wdata_q;
         end
`ifdef MISALIGN_SPLIT_EN
         SPLIT: begin
            mem_en     = 1'b1;
            mem_wr     = wr_q;
            mem_addr   = addr_q + ADDR_W'(idx_q);
            mem_wdata  = {24'h0, wdata_q[{idx_q, 3'b000} +: 8]};
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a byte-addressed memory behaves like
// memory2c, and a request-level reference model predicts responses, latency,
// memory traffic and memory contents. Honours MISALIGN_SPLIT_EN.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

   localparam int ADDR_W = 32;

`ifdef MISALIGN_SPLIT_EN
   localparam bit SPLIT_ON = 1'b1;
`else
   localparam bit SPLIT_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_wr = 1'b0;
   logic [2:0]        req_funct3 = 3'b000;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = 32'h0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_fault;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_length;
   logic              mem_sign;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .mem_en     (mem_en),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_length (mem_length),
      .mem_sign   (mem_sign),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- memory2c-like data memory ----------------
   logic [7:0]  dmem    [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];
   int          mem_upd = 0;
   logic [31:0] rd_word;

   function automatic logic [7:0] dm_rd(input logic [31:0] a);
      if (dmem.exists(a)) return dmem[a];
      return 8'h00;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 8'h00;
   endfunction

   always @(mem_en or mem_addr or mem_length or mem_sign or mem_upd) begin
      rd_word = {dm_rd(mem_addr + 32'd3), dm_rd(mem_addr + 32'd2),
                 dm_rd(mem_addr + 32'd1), dm_rd(mem_addr)};
      mem_rdata = 32'h0;
      if (mem_en) begin
         case (mem_length)
            2'b00:   mem_rdata = mem_sign ? {{24{rd_word[7]}}, rd_word[7:0]} : {24'h0, rd_word[7:0]};
            2'b01:   mem_rdata = mem_sign ? {{16{rd_word[15]}}, rd_word[15:0]} : {16'h0, rd_word[15:0]};
            2'b10:   mem_rdata = rd_word;
            default: mem_rdata = 32'h0;
         endcase
      end
   end

   always @(posedge clk) begin
      if (mem_en && mem_wr && mem_length <= 2'b10) begin
         for (int i = 0; i < (1 << mem_length); i++) dmem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
         mem_upd++;
      end
   end

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      dmem[a]    = b;
      ref_mem[a] = b;
      mem_upd++;
   endtask

   // ---------------- one request against the reference model ----------------
   logic [31:0] last_addr [4];
   logic [1:0]  last_len;
   logic [31:0] last_rdata;
   logic        last_fault;

   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
      bit          legal, mis, e_fault;
      int          n, e_lat, e_en, lat, en_cnt;
      longint      v;
      logic [31:0] e_rdata;

      legal   = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      n       = 1 << f3[1:0];
      mis     = legal && ((addr % n) != 0);
      e_fault = !legal || (mis && !SPLIT_ON);
      e_lat   = e_fault ? 1 : (mis ? 1 + n : 2);
      e_en    = e_fault ? 0 : (mis ? n : 1);
      e_rdata = 32'h0;
      if (!e_fault) begin
         if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
         end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_rd(addr + 32'(i))) << (8*i);
            if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
            e_rdata = v[31:0];
         end
      end

      req_wr = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      check("ready_idle", req_ready, 1'b1);
      @(posedge clk);
      #1;
      // unrelated request held while busy must be ignored
      req_wr = ~wr; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      lat = 0; en_cnt = 0; last_len = 2'b11;
      last_rdata = 32'hxxxxxxxx; last_fault = 1'bx;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_en) begin
            if (en_cnt < 4) last_addr[en_cnt] = mem_addr;
            if (en_cnt == 0) last_len = mem_length;
            check("mem_wr", mem_wr, wr);
            check("mem_addr", mem_addr, mis ? addr + 32'(en_cnt) : addr);
            check("mem_len", mem_length, mis ? 2'b00 : f3[1:0]);
            if (wr && mis) check("mem_wbyte", mem_wdata[7:0], wdata[8*en_cnt +: 8]);
            if (wr && !mis) check("mem_wdata", mem_wdata, wdata);
            en_cnt++;
         end
         check("ready_busy", req_ready, 1'b0);
         if (resp_valid) begin
            lat        = c;
            last_rdata = resp_rdata;
            last_fault = resp_fault;
            req_valid  = 1'b0;
            break;
         end
      end
      req_valid = 1'b0;
      check("latency", lat, e_lat);
      check("resp_fault", last_fault, e_fault);
      check("resp_rdata", last_rdata, e_rdata);
      check("mem_en_cycles", en_cnt, e_en);
      @(negedge clk);
      check("resp_pulse", resp_valid, 1'b0);
      check("ready_after", req_ready, 1'b1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a;
      logic        seen_resp;

      #1;
      check("rst_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_fault", resp_fault, 1'b0);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_wr", mem_wr, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_len", mem_length, 2'b00);
      check("rst_mem_sign", mem_sign, 1'b0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // aligned lw
      preload(32'h100, 8'hEF); preload(32'h101, 8'hBE);
      preload(32'h102, 8'hAD); preload(32'h103, 8'hDE);
      do_req(1'b0, 3'b010, 32'h100, 32'h0);
      check("lw_data", last_rdata, 32'hDEADBEEF);
      check("lw_len", last_len, 2'b10);

      // lb / lbu of 0x80
      do_req(1'b1, 3'b000, 32'h100, 32'h0000_0080);
      do_req(1'b0, 3'b000, 32'h100, 32'h0);
      check("lb_data", last_rdata, 32'hFFFFFF80);
      do_req(1'b0, 3'b100, 32'h100, 32'h0);
      check("lbu_data", last_rdata, 32'h00000080);

      // misaligned sw then lw at 0x203
      do_req(1'b1, 3'b010, 32'h203, 32'h11223344);
      do_req(1'b0, 3'b010, 32'h203, 32'h0);
`ifdef MISALIGN_SPLIT_EN
      check("split_lw_data", last_rdata, 32'h11223344);
      check("split_sw_b3", dm_rd(32'h206), 8'h11);
`else
      check("nosplit_lw_fault", last_fault, 1'b1);
      check("nosplit_sw_untouched", dm_rd(32'h203), 8'h00);
`endif

      // illegal load funct3
      do_req(1'b0, 3'b011, 32'h100, 32'h0);
      check("illegal_fault", last_fault, 1'b1);

      // split lh across the address wrap
      preload(32'hFFFFFFFF, 8'h34); preload(32'h0, 8'h92);
      do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
`ifdef MISALIGN_SPLIT_EN
      check("wrap_lh_data", last_rdata, 32'hFFFF9234);
      check("wrap_addr0", last_addr[0], 32'hFFFFFFFF);
      check("wrap_addr1", last_addr[1], 32'h0);
`else
      check("wrap_lh_fault", last_fault, 1'b1);
`endif

      // reset in the middle of a store
      for (int i = 0; i < 4; i++) preload(32'h303 + 32'(i), 8'hA0 + 8'(i));
      req_wr = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h11223344; req_valid = 1'b1;
`ifdef MISALIGN_SPLIT_EN
      req_addr = 32'h303;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);             // first SPLIT cycle
      @(negedge clk);             // second SPLIT cycle, first byte already written
      #1 rst_n = 1'b0;
      #1 check("abort_mem_en", mem_en, 1'b0);
      ref_mem[32'h303] = 8'h44;
`else
      req_addr = 32'h304;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);             // ACCESS cycle, nothing written yet
      #1 rst_n = 1'b0;
      #1 check("abort_mem_en", mem_en, 1'b0);
`endif
      @(negedge clk);
      #2 rst_n = 1'b1;
      seen_resp = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (resp_valid) seen_resp = 1'b1;
      end
      check("abort_no_resp", seen_resp, 1'b0);
      check("abort_ready", req_ready, 1'b1);
      for (int i = 0; i < 4; i++) check("abort_mem", dm_rd(32'h303 + 32'(i)), ref_rd(32'h303 + 32'(i)));

      // randomized traffic
      for (int i = 0; i < 64; i++) preload(32'h400 + 32'(i), 8'($urandom));
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
         else                           a = 32'h400 + 32'($urandom_range(0, 60));
         do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
